// File: rtl/seq_shifter_if.sv
// Request/result bundle for seq_shifter; the arith field exists only with SEQ_SHIFTER_ARITH_EN.
// Pure wiring, no latency; the requester must hold off start while busy is high.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] rt;
    logic [AMT_W-1:0] imm;
    logic             control;
`ifdef SEQ_SHIFTER_ARITH_EN
    logic             arith;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shiftresult;

    modport master (
`ifdef SEQ_SHIFTER_ARITH_EN
        output arith,
`endif
        output start, rt, imm, control,
        input  busy, done, shiftresult
    );

    modport slave (
`ifdef SEQ_SHIFTER_ARITH_EN
        input  arith,
`endif
        input  start, rt, imm, control,
        output busy, done, shiftresult
    );
endinterface

// File: rtl/seq_shifter.sv
// Iterative shifter, one bit per clock; SEQ_SHIFTER_ARITH_EN adds arithmetic right shifts.
// Latency: done pulses min(imm,WIDTH)+1 cycles after start is accepted.
// Backpressure: start is honoured only in IDLE; requests while busy are dropped, not queued.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    seq_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] opnd;
    logic             dir_left;
    logic             fill;
    logic             load_fill;

    assign amt_clamped = (bus.imm > WIDTH_AMT) ? WIDTH_AMT : bus.imm;

    // Fill bit is fixed at capture so later changes on rt cannot leak into the shift.
`ifdef SEQ_SHIFTER_ARITH_EN
    assign load_fill = ~bus.control & bus.arith & bus.rt[WIDTH-1];
`else
    assign load_fill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (amt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            opnd     <= '0;
            dir_left <= 1'b0;
            fill     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= amt_clamped;
                        opnd     <= bus.rt;
                        dir_left <= bus.control;
                        fill     <= load_fill;
                    end
                end
                SHIFT: begin
                    opnd <= dir_left ? {opnd[WIDTH-2:0], 1'b0} : {fill, opnd[WIDTH-1:1]};
                    cnt  <= cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.shiftresult = opnd;
endmodule
